// File: rtl/bws_pkg.sv
// Package for bayer_window_stream: shared widths, limits, FSM state type and
// the coordinate type. Imported by every other file of the block.
package bws_pkg;
  localparam int COORD_W    = 13;
  localparam int MAX_HEIGHT = 4096;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bws_state_t;
  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/bayer_window_stream_lb.sv
// bws_line_buffer: one row of pixel storage for the window former.
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   addr   in   shared read/write column address
//   wdata  in   pixel to store
//   rdata  out  asynchronous read of addr (returns the pre-write value in a
//               cycle that also writes addr)
// Contents are deliberately not reset.
module bws_line_buffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         wdata,
  output logic [PIX_W-1:0]         rdata
);
  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/bayer_window_stream.sv
// bayer_window_stream: turns a raster pixel stream into WIN x WIN windows
// tagged with the row/column of the bottom-right pixel.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, cfg_width/height  frame start pulse and frame size (sampled on start)
//   s_valid/s_ready/s_pixel  input pixel stream
//   m_valid/m_ready          output window handshake
//   m_window, m_row, m_col   window (element (r,c) at [(r*WIN+c)*PIX_W +: PIX_W])
//   busy, frame_done         status; cfg_err sticky illegal-config flag
//   stall_cnt                present only when BWS_STALL_CNT_EN is defined
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels
// DRAIN | last pixel taken, waiting for final window handoff
// DONE  | frame_done pulse, back to IDLE next cycle
module bayer_window_stream
  import bws_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int WIN       = 2,
  parameter int MAX_WIDTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COORD_W-1:0]       cfg_width,
  input  logic [COORD_W-1:0]       cfg_height,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_pixel,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIN*WIN*PIX_W-1:0] m_window,
  output logic [COORD_W-1:0]       m_row,
  output logic [COORD_W-1:0]       m_col,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     cfg_err
`ifdef BWS_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);
  localparam int     AW     = $clog2(MAX_WIDTH);
  localparam coord_t WIN_C  = coord_t'(WIN);
  localparam coord_t EDGE_C = coord_t'(WIN - 1);
  localparam coord_t MAXW_C = coord_t'(MAX_WIDTH);
  localparam coord_t MAXH_C = coord_t'(MAX_HEIGHT);

  typedef logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win_t;

  bws_state_t state_q;
  coord_t     width_q, height_q, col_q, row_q, m_row_q, m_col_q;
  win_t       sr_q, sr_d, win_q;
  logic       m_valid_q, busy_q, frame_done_q, cfg_err_q;

  logic [PIX_W-1:0] lb_rd [WIN-1];
  logic [PIX_W-1:0] lb_wr [WIN-1];

  logic accept, emit, last_col, last_row, legal;

  assign s_ready  = (state_q == RUN) && (!m_valid_q || m_ready);
  assign accept   = s_valid && s_ready;
  assign emit     = (row_q >= EDGE_C) && (col_q >= EDGE_C);
  assign last_col = (col_q == width_q - coord_t'(1));
  assign last_row = (row_q == height_q - coord_t'(1));
  assign legal    = (cfg_width >= WIN_C) && (cfg_width <= MAXW_C) &&
                    (cfg_height >= WIN_C) && (cfg_height <= MAXH_C);

  // Buffer k holds the row k+1 above the current one; accepting a pixel
  // pushes each column one buffer deeper.
  always_comb begin
    lb_wr[0] = s_pixel;
    for (int k = 1; k < WIN - 1; k++) lb_wr[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    bws_line_buffer #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH)) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q[AW-1:0]),
      .wdata (lb_wr[k]),
      .rdata (lb_rd[k])
    );
  end

  // Shift-register view after this accept: columns move left, the new
  // rightmost column is (oldest buffer .. newest buffer, incoming pixel).
  always_comb begin
    sr_d = sr_q;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN - 1; c++) sr_d[r][c] = sr_q[r][c+1];
    for (int r = 0; r < WIN - 1; r++) sr_d[r][WIN-1] = lb_rd[WIN-2-r];
    sr_d[WIN-1][WIN-1] = s_pixel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      sr_q         <= '0;
      win_q        <= '0;
      m_row_q      <= '0;
      m_col_q      <= '0;
      m_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (accept && emit) begin
        m_valid_q <= 1'b1;
        win_q     <= sr_d;
        m_row_q   <= row_q;
        m_col_q   <= col_q;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (accept) begin
        if (last_col) begin
          sr_q  <= '0;
          col_q <= '0;
          row_q <= row_q + coord_t'(1);
        end else begin
          sr_q  <= sr_d;
          col_q <= col_q + coord_t'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (legal) begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              cfg_err_q <= 1'b0;
              width_q   <= cfg_width;
              height_q  <= cfg_height;
              col_q     <= '0;
              row_q     <= '0;
              sr_q      <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept && last_col && last_row) begin
            state_q <= DRAIN;
            busy_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (!m_valid_q || m_ready) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BWS_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start && legal) begin
      stall_q <= '0;
    end else if (m_valid_q && !m_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign m_valid    = m_valid_q;
  assign m_window   = win_q;
  assign m_row      = m_row_q;
  assign m_col      = m_col_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_bayer_window_stream.sv
module tb_bayer_window_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start2 = 1'b0, start3 = 1'b0;
  logic [12:0] cfg_width = '0, cfg_height = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_pixel = '0;
  logic        m_ready = 1'b1;

  logic        s_ready2, m_valid2, busy2, frame_done2, cfg_err2;
  logic [31:0] m_window2;
  logic [12:0] m_row2, m_col2;
  logic        s_ready3, m_valid3, busy3, frame_done3, cfg_err3;
  logic [71:0] m_window3;
  logic [12:0] m_row3, m_col3;
`ifdef BWS_STALL_CNT_EN
  logic [15:0] stall_cnt2, stall_cnt3;
`endif

  always #5 clk = ~clk;

  bayer_window_stream #(.PIX_W(8), .WIN(2), .MAX_WIDTH(4096)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_valid(s_valid), .s_ready(s_ready2), .s_pixel(s_pixel),
    .m_valid(m_valid2), .m_ready(m_ready), .m_window(m_window2), .m_row(m_row2), .m_col(m_col2),
    .busy(busy2), .frame_done(frame_done2), .cfg_err(cfg_err2)
`ifdef BWS_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  bayer_window_stream #(.PIX_W(8), .WIN(3), .MAX_WIDTH(4096)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_valid(s_valid), .s_ready(s_ready3), .s_pixel(s_pixel),
    .m_valid(m_valid3), .m_ready(m_ready), .m_window(m_window3), .m_row(m_row3), .m_col(m_col3),
    .busy(busy3), .frame_done(frame_done3), .cfg_err(cfg_err3)
`ifdef BWS_STALL_CNT_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

  typedef struct packed {
    logic [71:0] win;
    logic [12:0] row;
    logic [12:0] col;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];

  int n_chk = 0, n_fail = 0;
  int nwin2 = 0, nwin3 = 0, nfd2 = 0, nfd3 = 0, stall_obs = 0;
  logic [31:0] first2, last2;
  logic [25:0] first_rc2, last_rc2;
  logic [71:0] centre3;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: compares the presented window against the queue head
  // on every valid cycle (so a stalled window must also stay correct) and
  // retires the entry when the handshake completes at the next edge.
  always @(negedge clk) begin
    if (m_valid2) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL extra_window2: got row %0d col %0d, required no window", m_row2, m_col2);
      end else begin
        chk("win2", {40'd0, m_window2}, q2[0].win);
        chk("row2", {59'd0, m_row2}, {59'd0, q2[0].row});
        chk("col2", {59'd0, m_col2}, {59'd0, q2[0].col});
        if (m_ready) begin
          if (nwin2 == 0) begin first2 = m_window2; first_rc2 = {m_row2, m_col2}; end
          last2 = m_window2; last_rc2 = {m_row2, m_col2};
          void'(q2.pop_front());
          nwin2++;
        end
      end
    end
    if (m_valid3) begin
      if (q3.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL extra_window3: got row %0d col %0d, required no window", m_row3, m_col3);
      end else begin
        chk("win3", m_window3, q3[0].win);
        chk("row3", {59'd0, m_row3}, {59'd0, q3[0].row});
        chk("col3", {59'd0, m_col3}, {59'd0, q3[0].col});
        if (m_ready) begin
          if (m_row3 == 13'd3 && m_col3 == 13'd3) centre3 = m_window3;
          void'(q3.pop_front());
          nwin3++;
        end
      end
    end
    if (frame_done2) nfd2++;
    if (frame_done3) nfd3++;
    if (m_valid2 && !m_ready) stall_obs++;
  end

  function automatic logic [7:0] pv(input int seed, input int w, input int r, input int c);
    return 8'(seed + r * w + c);
  endfunction

  task automatic step(input bit tog);
    @(posedge clk); #1;
    if (tog) m_ready = ~m_ready;
  endtask

  task automatic do_start(input bit sel, input int w, input int h);
    cfg_width = 13'(w); cfg_height = 13'(h);
    if (sel) start3 = 1'b1; else start2 = 1'b1;
    step(1'b0);
    start2 = 1'b0; start3 = 1'b0;
  endtask

  // Feeds a raster frame; pushes the expected window for every pixel that
  // completes one. stop_at aborts before that pixel index; inj_at pulses a
  // start with a different width alongside that pixel.
  task automatic feed(input bit sel, input int w, input int h, input int win, input int seed,
                      input bit tog, input int stop_at, input int inj_at);
    int n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        bit ok = 1'b0;
        int budget = 0;
        if (n == stop_at) return;
        if (n == inj_at) begin
          cfg_width = 13'(w + 2);
          if (sel) start3 = 1'b1; else start2 = 1'b1;
        end
        s_valid = 1'b1;
        s_pixel = pv(seed, w, r, c);
        while (!ok) begin
          @(negedge clk);
          ok = sel ? s_ready3 : s_ready2;
          if (ok && r >= win - 1 && c >= win - 1) begin
            exp_t e;
            e = '0;
            for (int rr = 0; rr < win; rr++)
              for (int cc = 0; cc < win; cc++)
                e.win[(rr * win + cc) * 8 +: 8] = pv(seed, w, r - win + 1 + rr, c - win + 1 + cc);
            e.row = 13'(r);
            e.col = 13'(c);
            if (sel) q3.push_back(e); else q2.push_back(e);
          end
          step(tog);
          start2 = 1'b0; start3 = 1'b0;
          budget++;
          if (!ok && budget > 50) begin
            chk("s_ready_timeout", 72'd0, 72'd1);
            s_valid = 1'b0;
            return;
          end
        end
        n++;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit sel, input bit tog);
    int n = 0;
    while ((sel ? nfd3 : nfd2) == 0 && n < 40) begin
      step(tog);
      n++;
    end
    repeat (4) step(tog);
    m_ready = 1'b1;
    step(1'b0);
    chk(sel ? "frame_done_count3" : "frame_done_count2", 72'(sel ? nfd3 : nfd2), 72'd1);
    chk(sel ? "queue_empty3" : "queue_empty2", 72'(sel ? q3.size() : q2.size()), 72'd0);
    chk(sel ? "busy_after3" : "busy_after2", {71'd0, sel ? busy3 : busy2}, 72'd0);
  endtask

  task automatic frame_4x3_test1;
    nwin2 = 0; nfd2 = 0;
    do_start(1'b0, 4, 3);
    chk("busy_run", {71'd0, busy2}, 72'd1);
    feed(1'b0, 4, 3, 2, 0, 1'b0, -1, -1);
    finish_frame(1'b0, 1'b0);
    chk("t1_count", 72'(nwin2), 72'd6);
    chk("t1_first", {40'd0, first2}, 72'h05040100);
    chk("t1_first_rc", {46'd0, first_rc2}, {46'd0, 13'd1, 13'd1});
    chk("t1_last", {40'd0, last2}, 72'h0B0A0706);
    chk("t1_last_rc", {46'd0, last_rc2}, {46'd0, 13'd2, 13'd3});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", {71'd0, m_valid2}, 72'd0);
    chk("rst_s_ready", {71'd0, s_ready2}, 72'd0);
    chk("rst_busy", {71'd0, busy2}, 72'd0);
    chk("rst_cfg_err", {71'd0, cfg_err2}, 72'd0);
    chk("rst_m_window", {40'd0, m_window2}, 72'd0);
    chk("rst_frame_done", {71'd0, frame_done2}, 72'd0);
    rst = 1'b0;
    step(1'b0);

    // 1: WIN=2, 4x3 ramp
    frame_4x3_test1();

    // 2: WIN=3, 5x5 ramp
    nwin3 = 0; nfd3 = 0;
    do_start(1'b1, 5, 5);
    feed(1'b1, 5, 5, 3, 0, 1'b0, -1, -1);
    finish_frame(1'b1, 1'b0);
    chk("t2_count", 72'(nwin3), 72'd9);
    chk("t2_centre", centre3, {8'd18, 8'd17, 8'd16, 8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6});
`ifdef BWS_STALL_CNT_EN
    chk("t2_stall_cnt", {56'd0, stall_cnt3}, 72'd0);
`endif

    // 3: m_ready toggling every cycle
    nwin2 = 0; nfd2 = 0; stall_obs = 0;
    do_start(1'b0, 5, 4);
    feed(1'b0, 5, 4, 2, 37, 1'b1, -1, -1);
    finish_frame(1'b0, 1'b1);
    chk("t3_count", 72'(nwin2), 72'd12);
    chk("t3_stalls_seen", {71'd0, (stall_obs > 0) ? 1'b1 : 1'b0}, 72'd1);
`ifdef BWS_STALL_CNT_EN
    chk("t3_stall_cnt", {56'd0, stall_cnt2}, 72'(stall_obs));
`endif

    // 4: illegal configs, then a legal 8x8
    do_start(1'b0, 1, 8);
    step(1'b0);
    chk("t4_err_w1", {71'd0, cfg_err2}, 72'd1);
    chk("t4_busy_w1", {71'd0, busy2}, 72'd0);
    chk("t4_sready_w1", {71'd0, s_ready2}, 72'd0);
    do_start(1'b0, 4097, 8);
    step(1'b0);
    chk("t4_err_w4097", {71'd0, cfg_err2}, 72'd1);
    chk("t4_busy_w4097", {71'd0, busy2}, 72'd0);
    nwin2 = 0; nfd2 = 0;
    do_start(1'b0, 8, 8);
    chk("t4_err_clear", {71'd0, cfg_err2}, 72'd0);
    chk("t4_busy_legal", {71'd0, busy2}, 72'd1);
    feed(1'b0, 8, 8, 2, 200, 1'b0, -1, -1);
    finish_frame(1'b0, 1'b0);
    chk("t4_count", 72'(nwin2), 72'd49);

    // 5: reset in the middle of row 2, then a clean repeat of test 1
    do_start(1'b0, 4, 3);
    feed(1'b0, 4, 3, 2, 0, 1'b0, 10, -1);
    chk("t5_valid_before", {71'd0, m_valid2}, 72'd1);
    rst = 1'b1;
    q2.delete();
    #1;
    chk("t5_m_valid", {71'd0, m_valid2}, 72'd0);
    chk("t5_m_window", {40'd0, m_window2}, 72'd0);
    chk("t5_m_row_col", {46'd0, m_row2, m_col2}, 72'd0);
    chk("t5_busy", {71'd0, busy2}, 72'd0);
    chk("t5_s_ready", {71'd0, s_ready2}, 72'd0);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    frame_4x3_test1();

    // 6: start during RUN with a different width is ignored
    nwin2 = 0; nfd2 = 0;
    do_start(1'b0, 4, 3);
    feed(1'b0, 4, 3, 2, 100, 1'b0, -1, 5);
    finish_frame(1'b0, 1'b0);
    chk("t6_count", 72'(nwin2), 72'd6);
    chk("t6_cfg_err", {71'd0, cfg_err2}, 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, required finish");
    $fatal(1, "timeout");
  end
endmodule
